// File: rtl/fp2int_pkg.sv
// Shared IEEE-754 single-precision field layout, classes and integer limits
// used by the float-to-int converter.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam int SIG_W = MAN_W + 1;
  localparam int INT_W = 32;

  localparam logic [INT_W-1:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [INT_W-1:0] INT_MIN = 32'h8000_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_t;

  // Denormals fold into FP_ZERO: they always truncate to 0.
  function automatic fp_class_t fp_classify(input fp32_t f);
    fp_class_t c;
    c = FP_NORM;
    if (f.exp == '0) begin
      c = FP_ZERO;
    end else if (f.exp == '1) begin
      c = (f.man == '0) ? FP_INF : FP_NAN;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp2int_align_sticky.sv
// Combinational significand aligner: right shift with sticky (OR of the bits
// shifted out) or left shift into the 32-bit magnitude.
module align_sticky
  import fp_pkg::*;
(
  input  logic [SIG_W-1:0] i_sig,
  input  logic             i_rshift,
  input  logic [4:0]       i_amt,
  output logic [INT_W-1:0] o_mag,
  output logic             o_sticky
);

  logic [2*SIG_W-1:0] w_rwide;
  logic [INT_W-1:0]   w_lwide;

  // The low half of the widened right shift collects exactly the lost bits.
  assign w_rwide = {i_sig, {SIG_W{1'b0}}} >> i_amt;
  assign w_lwide = {{(INT_W-SIG_W){1'b0}}, i_sig} << i_amt;

  always_comb begin
    o_mag    = w_lwide;
    o_sticky = 1'b0;
    if (i_rshift) begin
      o_mag    = {{(INT_W-SIG_W){1'b0}}, w_rwide[2*SIG_W-1 -: SIG_W]};
      o_sticky = |w_rwide[SIG_W-1:0];
    end
  end

endmodule

// File: rtl/fp2int.sv
// Three-stage float32 -> int32 converter, truncating toward zero with
// saturation; a single global enable stalls every stage together.
module fp2int
  import fp_pkg::*;
#(
  parameter int N    = 32,
  parameter int W    = 32,
  parameter int BIAS = fp_pkg::BIAS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         invalid,
  output logic         inexact
);

  // Handshake: a word moves on any edge where valid && ready; the output
  // register holds while out_valid && !out_ready, and that freezes all stages.
  logic w_en;
  logic r_out_valid;

  assign w_en     = !(r_out_valid && !out_ready);
  assign in_ready = w_en;

  // ---------------- S1: unpack / classify ----------------
  fp32_t             w_f;
  fp_class_t         w_cls;
  logic signed [8:0] w_e;

  assign w_f   = a;
  assign w_cls = fp_classify(w_f);
  assign w_e   = $signed({1'b0, w_f.exp}) - $signed(9'(BIAS));

  logic              r1_valid;
  logic              r1_sign;
  logic signed [8:0] r1_e;
  logic [SIG_W-1:0]  r1_sig;
  fp_class_t         r1_cls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_e     <= '0;
      r1_sig   <= '0;
      r1_cls   <= FP_ZERO;
    end else if (w_en) begin
      r1_valid <= in_valid;
      r1_sign  <= w_f.sign;
      r1_e     <= w_e;
      r1_sig   <= {1'b1, w_f.man};
      r1_cls   <= w_cls;
    end
  end

  // ---------------- S2: align ----------------
  logic             w_rshift;
  logic [4:0]       w_amt;
  logic [INT_W-1:0] w_sh_mag;
  logic             w_sh_sticky;

  // Shift distances only matter inside 0..30, so 5-bit modular math suffices.
  assign w_rshift = (r1_e <= 9'sd23);
  assign w_amt    = w_rshift ? (5'd23 - r1_e[4:0]) : (r1_e[4:0] - 5'd23);

  align_sticky u_align (
    .i_sig    (r1_sig),
    .i_rshift (w_rshift),
    .i_amt    (w_amt),
    .o_mag    (w_sh_mag),
    .o_sticky (w_sh_sticky)
  );

  logic [W-1:0] w_mag;
  logic         w_inex;
  logic         w_ovf;
  logic         w_nan;
  logic         w_min;

  always_comb begin
    w_mag  = '0;
    w_inex = 1'b0;
    w_ovf  = 1'b0;
    w_nan  = 1'b0;
    w_min  = 1'b0;
    case (r1_cls)
      FP_ZERO: w_inex = |r1_sig[MAN_W-1:0];
      FP_NAN:  w_nan  = 1'b1;
      FP_INF:  w_ovf  = 1'b1;
      default: begin
        if (r1_e < 9'sd0) begin
          w_inex = 1'b1;
        end else if (r1_e <= 9'sd23) begin
          w_mag  = w_sh_mag;
          w_inex = w_sh_sticky;
        end else if (r1_e <= 9'sd30) begin
          w_mag  = w_sh_mag;
        end else begin
          // -2^31 is the one value with e == 31 that is representable.
          w_ovf = 1'b1;
          w_min = r1_sign && (r1_e == 9'sd31) && (r1_sig[MAN_W-1:0] == '0);
        end
      end
    endcase
  end

  logic         r2_valid;
  logic         r2_sign;
  logic [W-1:0] r2_mag;
  logic         r2_inex;
  logic         r2_ovf;
  logic         r2_nan;
  logic         r2_min;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid <= 1'b0;
      r2_sign  <= 1'b0;
      r2_mag   <= '0;
      r2_inex  <= 1'b0;
      r2_ovf   <= 1'b0;
      r2_nan   <= 1'b0;
      r2_min   <= 1'b0;
    end else if (w_en) begin
      r2_valid <= r1_valid;
      r2_sign  <= r1_sign;
      r2_mag   <= w_mag;
      r2_inex  <= w_inex;
      r2_ovf   <= w_ovf;
      r2_nan   <= w_nan;
      r2_min   <= w_min;
    end
  end

  // ---------------- S3: sign / saturate ----------------
  logic [W-1:0] w_out;
  logic         w_invalid;
  logic         w_inexact;

  always_comb begin
    w_out     = r2_sign ? (-r2_mag) : r2_mag;
    w_invalid = 1'b0;
    w_inexact = r2_inex;
    if (r2_nan) begin
      w_out     = INT_MAX;
      w_invalid = 1'b1;
      w_inexact = 1'b0;
    end else if (r2_ovf) begin
      w_inexact = 1'b0;
      if (r2_min) begin
        w_out = INT_MIN;
      end else begin
        w_out     = r2_sign ? INT_MIN : INT_MAX;
        w_invalid = 1'b1;
      end
    end
  end

  logic [W-1:0] r_out;
  logic         r_invalid;
  logic         r_inexact;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_invalid   <= 1'b0;
      r_inexact   <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r2_valid;
      r_out       <= w_out;
      r_invalid   <= w_invalid;
      r_inexact   <= w_inexact;
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign invalid   = r_invalid;
  assign inexact   = r_inexact;

endmodule

// File: tb/tb_fp2int.sv
// Directed bench for fp2int: hand-computed vectors, a stall burst and a
// mid-stream reset, with results matched in order through an expected queue.
module tb_fp2int;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [31:0] a         = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic        invalid;
  logic        inexact;

  // Expected entries are {invalid, inexact, out}.
  logic [33:0] exp_q[$];
  logic [33:0] cur_exp = '0;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_out    = 0;

  always #5 clk = ~clk;

  fp2int dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .invalid   (invalid),
    .inexact   (inexact)
  );

  function automatic logic [33:0] mk(input logic inv, input logic inex, input logic [31:0] v);
    return {inv, inex, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // One clock: handshakes are sampled before the edge, state observed 1ns after.
  task automatic tick();
    logic        acc;
    logic        deq;
    logic [33:0] got;
    acc = in_valid && in_ready;
    deq = out_valid && out_ready;
    got = {invalid, inexact, out};
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back(cur_exp);
    if (deq) begin
      n_out++;
      chk("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("result", got, exp_q.pop_front());
    end
  endtask

  // Leaves in_valid high so consecutive sends stream back-to-back.
  task automatic send(input logic [31:0] val, input logic [33:0] e);
    logic acc;
    int   guard;
    in_valid = 1'b1;
    a        = val;
    cur_exp  = e;
    guard    = 0;
    do begin
      acc = in_ready;
      tick();
      guard++;
    end while (!acc && guard < 50);
    chk("send_accept", acc, 1);
  endtask

  task automatic drain();
    int guard;
    in_valid = 1'b0;
    guard    = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      tick();
      guard++;
    end
    chk("drain_empty", exp_q.size(), 0);
    repeat (4) tick();
  endtask

  logic [31:0] vin[16];
  logic [33:0] vexp[16];

  initial begin
    int lat;
    int n0;

    vin[0]  = 32'hC020_0000; vexp[0]  = mk(0, 1, 32'hFFFF_FFFE); // -2.5
    vin[1]  = 32'h3EFF_FFFF; vexp[1]  = mk(0, 1, 32'h0000_0000); // ~0.4999
    vin[2]  = 32'h4F00_0000; vexp[2]  = mk(1, 0, 32'h7FFF_FFFF); // 2^31
    vin[3]  = 32'hCF00_0000; vexp[3]  = mk(0, 0, 32'h8000_0000); // -2^31 exact
    vin[4]  = 32'hFF80_0000; vexp[4]  = mk(1, 0, 32'h8000_0000); // -inf
    vin[5]  = 32'h7FC0_0000; vexp[5]  = mk(1, 0, 32'h7FFF_FFFF); // qNaN
    vin[6]  = 32'h4EFF_FFFF; vexp[6]  = mk(0, 0, 32'h7FFF_FF80); // largest exact
    vin[7]  = 32'h8000_0000; vexp[7]  = mk(0, 0, 32'h0000_0000); // -0.0
    vin[8]  = 32'h0000_0001; vexp[8]  = mk(0, 1, 32'h0000_0000); // denormal
    vin[9]  = 32'h7F80_0000; vexp[9]  = mk(1, 0, 32'h7FFF_FFFF); // +inf
    vin[10] = 32'h3F7F_FFFF; vexp[10] = mk(0, 1, 32'h0000_0000); // just below 1
    vin[11] = 32'h4B00_0001; vexp[11] = mk(0, 0, 32'h0080_0001); // e=23
    vin[12] = 32'hCEFF_FFFF; vexp[12] = mk(0, 0, 32'h8000_0080); // -2147483520
    vin[13] = 32'hCF00_0001; vexp[13] = mk(1, 0, 32'h8000_0000); // below -2^31
    vin[14] = 32'h3FC0_0000; vexp[14] = mk(0, 1, 32'h0000_0001); // 1.5
    vin[15] = 32'h4000_0000; vexp[15] = mk(0, 0, 32'h0000_0002); // 2.0

    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_invalid", invalid, 0);
    chk("rst_inexact", inexact, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1.0 alone: out_valid after the third edge counting the acceptance edge
    send(32'h3F80_0000, mk(0, 0, 32'h0000_0001));
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("latency", lat, 3);
    drain();

    // Directed vectors streamed back-to-back
    for (int i = 0; i < 16; i++) send(vin[i], vexp[i]);
    drain();

    // Stream 1,2,3,4 and stall two cycles once the first result has left
    n0 = n_out;
    in_valid = 1'b1;
    a = 32'h3F80_0000; cur_exp = mk(0, 0, 32'd1); tick();
    a = 32'h4000_0000; cur_exp = mk(0, 0, 32'd2); tick();
    a = 32'h4040_0000; cur_exp = mk(0, 0, 32'd3); tick();
    chk("stream_first_valid", out_valid, 1);
    a = 32'h4080_0000; cur_exp = mk(0, 0, 32'd4);
    chk("in_ready_before_stall", in_ready, 1);
    tick();
    // Offered during the stall and must be ignored
    a = 32'h4120_0000; cur_exp = mk(0, 0, 32'd10);
    out_ready = 1'b0;
    #1;
    chk("in_ready_stall_0", in_ready, 0);
    chk("stall_out_0", out, 32'd2);
    tick();
    chk("in_ready_stall_1", in_ready, 0);
    chk("stall_hold_valid", out_valid, 1);
    chk("stall_hold_out", out, 32'd2);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("in_ready_after_stall", in_ready, 1);
    drain();
    chk("stream_count", n_out - n0, 4);

    // Reset with two words in flight while the output is stalled
    out_ready = 1'b0;
    send(32'h40A0_0000, mk(0, 0, 32'd5));
    send(32'h40C0_0000, mk(0, 0, 32'd6));
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("pre_reset_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_drop_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 1);
    exp_q.delete();
    tick();
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_stale", out_valid, 0);
    end
    send(32'h4040_0000, mk(0, 0, 32'd3));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
